ucie_ctl_rx_flit_assembler: RTL
===============================

Name: ucie_ctl_rx_flit_assembler

Overview:
- Sits directly downstream of the RX top and consumes its FDI-side output (o_fdi_data / o_fdi_data_valid).
- Gathers BEATS consecutive FDI beats into one full flit and hands the flit to the protocol layer over a valid/ready handshake.
- Flushes partial flits when the link leaves the active state.
- Flags flits lost because the protocol layer did not drain the output register in time.

Parameters:
- NBYTES, 32: width of one FDI beat in bits; matches the RX top data width.
- BEATS, 8: beats per flit. Must be >= 2.
- CNT_W, 16: width of the delivered-flit counter.

Ports:
- i_clk, input, 1: single clock.
- i_rst, input, 1: synchronous, active-high reset.
- i_state_request, input, 1: link-active indication, shared with the RX top. 1 = assemble beats.
- i_fdi_data, input, NBYTES: beat data from the RX top.
- i_fdi_data_valid, input, 1: beat valid from the RX top. There is no backpressure toward the RX top.
- i_flit_ready, input, 1: protocol layer accepts the flit.
- o_flit_data, output, NBYTES*BEATS: assembled flit. Beat k occupies bits [k*NBYTES +: NBYTES]; beat 0 is in the LSBs.
- o_flit_valid, output, 1: output register holds a flit.
- o_flit_drop, output, 1: one-cycle pulse when a completed flit is discarded.
- o_partial_flush, output, 1: one-cycle pulse when a partial flit is discarded.
- o_beat_idx, output, $clog2(BEATS): next beat slot to be written.
- o_flit_count, output, CNT_W: number of flits accepted by the protocol layer.

Behaviour:
- Clocking and reset: single clock domain. i_rst is synchronous, active-high, and has priority over everything else.
- Reset values:
  - o_flit_data = 0
  - o_flit_valid = 0, o_flit_drop = 0, o_partial_flush = 0
  - o_beat_idx = 0, o_flit_count = 0
  - assembly FSM = IDLE
- Assembly FSM:
  - IDLE: entered whenever i_state_request = 0. Beats are ignored and the beat index is held at 0. Moves to ASSEMBLE on the first cycle with i_state_request = 1.
  - ASSEMBLE: a beat is taken when i_fdi_data_valid = 1.
    - The beat is written into slot o_beat_idx of the assembly register.
    - o_beat_idx increments and wraps from BEATS-1 to 0.
  - ASSEMBLE -> IDLE when i_state_request = 0.
- i_state_request = 0 has priority over i_fdi_data_valid: a beat arriving in that cycle is dropped silently.
- Partial flush:
  - Trigger: i_state_request falls while o_beat_idx != 0.
  - o_partial_flush pulses for 1 cycle, in the cycle after the fall.
  - o_beat_idx is cleared to 0.
  - Discarded assembly contents are don't-care and need not be cleared.
- Flit completion: the beat written into slot BEATS-1 completes a flit.
  - Load condition: the output register is empty, or it is being drained in the same cycle (o_flit_valid & i_flit_ready). In that case the full flit, including the final beat, loads into o_flit_data.
  - On load, o_flit_valid = 1 in the next cycle. Latency from the final beat to o_flit_valid is 1 cycle.
  - Same-cycle drain and load: o_flit_valid stays 1 continuously and o_flit_data changes to the new flit.
  - Drop condition: o_flit_valid = 1 and i_flit_ready = 0. The completed flit is discarded and o_flit_drop pulses for 1 cycle in the next cycle.
  - On drop, the held flit is unchanged and o_beat_idx wraps to 0.
- Output handshake:
  - The flit transfers when o_flit_valid & i_flit_ready.
  - o_flit_valid falls the next cycle unless a new flit is loaded in the same cycle.
  - o_flit_data is stable while o_flit_valid = 1 and not accepted.
  - o_flit_data holds its last value after drain; it is not cleared.
- The output register is independent of i_state_request. A held flit remains deliverable while the link is inactive.
- o_flit_count increments by 1 on each accepted transfer and wraps modulo 2^CNT_W. No saturation.
- Sustained-rate requirement: with a beat every cycle and i_flit_ready = 1, there are no drops. o_flit_valid is high for 1 cycle per BEATS cycles.
- Reset mid-operation:
  - Partial assembly and any held flit are lost.
  - No o_flit_drop or o_partial_flush pulse is generated for them.
  - The next beat after reset fills slot 0.

Test Plan:
1. Reset: assert i_rst 2 cycles with i_fdi_data_valid = 1.
   -> All outputs 0 during and after reset; o_flit_valid = 0 until the first full flit.
2. Single flit: i_state_request = 1, i_flit_ready = 1, 8 beats with data 1..8.
   -> o_flit_valid = 1 one cycle after beat 8; o_flit_data = {8,7,...,1} (beat 1 in LSBs); o_flit_count = 1 after accept.
3. Back-pressure drop: i_flit_ready = 0, 16 back-to-back beats A0..A7, B0..B7.
   -> Flit A is held; o_flit_drop pulses once, the cycle after B7.
   -> Then raise i_flit_ready: o_flit_data = A, o_flit_count = 1, no second flit.
4. Streaming: i_flit_ready = 1, 24 back-to-back beats.
   -> 3 flits, o_flit_valid high exactly 3 single cycles spaced 8 apart, o_flit_drop never asserts, o_flit_count = 3.
5. Partial flush: 3 beats, then i_state_request = 0 for 2 cycles (valid beats presented meanwhile), then i_state_request = 1 and 8 new beats N0..N7.
   -> o_partial_flush single pulse; o_beat_idx = 0; next flit = N7..N0 only.
6. Reset mid-operation: one flit held (ready = 0) plus 5 beats assembled, then i_rst 1 cycle.
   -> o_flit_valid = 0, o_flit_count = 0, o_beat_idx = 0, no drop or flush pulse; next 8 beats yield a correct flit.

Source files
------------

// File: rtl/ucie_ctl_rx_flit_assembler_if.sv
// Bus bundle between the RX top / protocol layer and the flit assembler.
// slave  = the assembler (consumes beats, produces flits)
// master = the environment (produces beats, consumes flits)
interface ucie_ctl_rx_flit_assembler_if #(
  parameter int NBYTES = 32,
  parameter int BEATS  = 8,
  parameter int CNT_W  = 16
);
  localparam int IDX_W = $clog2(BEATS);

  logic                     i_state_request;
  logic [NBYTES-1:0]        i_fdi_data;
  logic                     i_fdi_data_valid;
  logic                     i_flit_ready;
  logic [NBYTES*BEATS-1:0]  o_flit_data;
  logic                     o_flit_valid;
  logic                     o_flit_drop;
  logic                     o_partial_flush;
  logic [IDX_W-1:0]         o_beat_idx;
  logic [CNT_W-1:0]         o_flit_count;
  logic                     dbg_assemble;   // 1 while the assembly FSM is in ASSEMBLE

  modport slave (
    input  i_state_request, i_fdi_data, i_fdi_data_valid, i_flit_ready,
    output o_flit_data, o_flit_valid, o_flit_drop, o_partial_flush,
           o_beat_idx, o_flit_count, dbg_assemble
  );

  modport master (
    output i_state_request, i_fdi_data, i_fdi_data_valid, i_flit_ready,
    input  o_flit_data, o_flit_valid, o_flit_drop, o_partial_flush,
           o_beat_idx, o_flit_count, dbg_assemble
  );
endinterface

// File: rtl/ucie_ctl_rx_flit_assembler.sv
// Gathers BEATS FDI beats into one flit and offers it to the protocol layer.
// Handshake: the flit transfers in any cycle where o_flit_valid & i_flit_ready;
// o_flit_data is held stable while valid and not accepted. The FDI side has
// no backpressure: a completed flit that cannot be loaded is dropped.
module ucie_ctl_rx_flit_assembler #(
  parameter int NBYTES = 32,
  parameter int BEATS  = 8,
  parameter int CNT_W  = 16
) (
  input logic                          i_clk,
  input logic                          i_rst,
  ucie_ctl_rx_flit_assembler_if.slave  bus
);
  localparam int IDX_W = $clog2(BEATS);
  localparam int ASM_W = NBYTES * (BEATS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  typedef enum logic {ST_IDLE, ST_ASSEMBLE} state_t;

  state_t                    state_q, state_d;
  logic [ASM_W-1:0]          asm_q;        // slots 0..BEATS-2; last beat goes straight to the output
  logic [NBYTES*BEATS-1:0]   flit_q;
  logic                      flit_valid_q;
  logic                      drop_q;
  logic                      flush_q;
  logic [IDX_W-1:0]          beat_idx_q;
  logic [CNT_W-1:0]          count_q;

  logic take, flush_cond, complete, accept, load;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: link-active request alone decides the assembly state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (bus.i_state_request)  state_d = ST_ASSEMBLE;
      ST_ASSEMBLE:  if (!bus.i_state_request) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and per-cycle decisions; request low overrides a valid beat.
  always_comb begin
    take       = bus.i_state_request & bus.i_fdi_data_valid;
    flush_cond = (state_q == ST_ASSEMBLE) & ~bus.i_state_request & (beat_idx_q != '0);
    complete   = take & (beat_idx_q == LAST_IDX);
    accept     = flit_valid_q & bus.i_flit_ready;
    load       = complete & (~flit_valid_q | bus.i_flit_ready);
  end

  // Beat slot index and assembly storage (contents are not reset; only the index matters).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      beat_idx_q <= '0;
    end else if (take) begin
      if (beat_idx_q != LAST_IDX) begin
        asm_q[int'(beat_idx_q)*NBYTES +: NBYTES] <= bus.i_fdi_data;
        beat_idx_q <= beat_idx_q + IDX_W'(1);
      end else begin
        beat_idx_q <= '0;
      end
    end else if (flush_cond) begin
      beat_idx_q <= '0;
    end
  end

  // Output register: load a completed flit when empty or draining this cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      flit_q       <= '0;
      flit_valid_q <= 1'b0;
    end else if (load) begin
      flit_q       <= {bus.i_fdi_data, asm_q};
      flit_valid_q <= 1'b1;
    end else if (accept) begin
      flit_valid_q <= 1'b0;
    end
  end

  // One-cycle event pulses for a lost completed flit and a discarded partial flit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      drop_q  <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      drop_q  <= complete & ~load;
      flush_q <= flush_cond;
    end
  end

  // Delivered-flit counter, wraps naturally.
  always_ff @(posedge i_clk) begin
    if (i_rst)       count_q <= '0;
    else if (accept) count_q <= count_q + CNT_W'(1);
  end

  assign bus.o_flit_data     = flit_q;
  assign bus.o_flit_valid    = flit_valid_q;
  assign bus.o_flit_drop     = drop_q;
  assign bus.o_partial_flush = flush_q;
  assign bus.o_beat_idx      = beat_idx_q;
  assign bus.o_flit_count    = count_q;
  assign bus.dbg_assemble    = (state_q == ST_ASSEMBLE);
endmodule
